vga_fb_scaler: RTL and testbench

Parametrised VGA display engine that replaces the fixed 640x480 timing generator. It owns a 1-bit-per-pixel framebuffer with a write port and a hardware clear engine. It scales the framebuffer to the active area by pixel replication and drives registered sync and 3-3-2 RGB outputs. It sits between the drawing logic (writer) and the VGA connector, in the pixel-clock domain.

---
 rtl/vga_fb_scaler_if.sv | 26 ++
 rtl/vga_fb_scaler.sv | 206 ++++++++++++++++++++
 tb/tb_vga_fb_scaler.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_scaler_if.sv
// Write/clear port of the VGA framebuffer scaler.
//   master: drawing logic driving wr_valid/wr_x/wr_y/wr_data/clr, seeing wr_ready/wr_err
//   slave : the scaler itself
// XW/YW must equal $clog2 of the framebuffer width/height of the attached scaler.
interface vga_fb_scaler_if #(
  parameter int unsigned XW = 9,
  parameter int unsigned YW = 8
) ();
  logic          wr_valid;
  logic          wr_ready;
  logic [XW-1:0] wr_x;
  logic [YW-1:0] wr_y;
  logic          wr_data;
  logic          wr_err;
  logic          clr;

  modport master (
    output wr_valid, wr_x, wr_y, wr_data, clr,
    input  wr_ready, wr_err
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_data, clr,
    output wr_ready, wr_err
  );
endinterface

// File: rtl/vga_fb_scaler.sv
// Parametrised VGA display engine with a 1-bpp framebuffer scaled by pixel replication.
//   clk, rst        : pixel clock, asynchronous active-high reset
//   wr              : write port (valid/ready, x, y, data, err pulse) and clear request
//   HS, VS          : registered syncs, polarity set by HS_POL/VS_POL
//   R, G, B         : registered 3-3-2 colour
//   vblank          : output line is outside the active area
//   frame_start     : one-cycle pulse with output pixel (0,0)
// Pipeline: counters -> registered memory read -> registered colour; all timing
// strobes are delayed to line up with the colour.
module vga_fb_scaler #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter logic        HS_POL      = 1'b0,
  parameter logic        VS_POL      = 1'b0,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter logic [7:0]  FG_COLOR    = 8'hFF,
  parameter logic [7:0]  BG_COLOR    = 8'h25
) (
  input  logic                  clk,
  input  logic                  rst,
  vga_fb_scaler_if.slave        wr,
  output logic                  HS,
  output logic                  VS,
  output logic [2:0]            R,
  output logic [2:0]            G,
  output logic [1:0]            B,
  output logic                  vblank,
  output logic                  frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned FB_W     = H_ACTIVE >> SCALE_SHIFT;
  localparam int unsigned FB_H     = V_ACTIVE >> SCALE_SHIFT;
  localparam int unsigned FB_SIZE  = FB_W * FB_H;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned AW       = $clog2(FB_SIZE);
  localparam int unsigned XW       = $clog2(FB_W);
  localparam int unsigned YW       = $clog2(FB_H);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  typedef enum logic {StIdle, StClear} state_e;

  // ---------------------------------------------------------------- counters
  logic [HW-1:0] h_q;
  logic [VW-1:0] v_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else if (h_q == HW'(H_TOTAL - 1)) begin
      h_q <= '0;
      v_q <= (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
    end else begin
      h_q <= h_q + HW'(1);
    end
  end

  // Stage 0: decode of the current counter position.
  logic          act0, hs0, vs0, vb0, fs0;
  logic [AW-1:0] rd_addr;

  always_comb begin
    act0    = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
    hs0     = (32'(h_q) >= HS_START && 32'(h_q) < HS_END) ? HS_POL : ~HS_POL;
    vs0     = (32'(v_q) >= VS_START && 32'(v_q) < VS_END) ? VS_POL : ~VS_POL;
    vb0     = 32'(v_q) >= V_ACTIVE;
    fs0     = (h_q == '0) && (v_q == '0);
    // Address is held at 0 in blanking so the read never leaves the array.
    rd_addr = '0;
    if (act0) begin
      rd_addr = AW'((32'(v_q) >> SCALE_SHIFT) * FB_W + (32'(h_q) >> SCALE_SHIFT));
    end
  end

  // ------------------------------------------------------------ write port
  logic [XW-1:0] wr_x;
  logic [YW-1:0] wr_y;
  logic          in_range, accept;
  logic [AW-1:0] wr_addr;

  state_e        state_q;
  logic [AW-1:0] clr_addr_q;
  logic          wr_ready_q, wr_err_q;

  assign wr_x     = wr.wr_x;
  assign wr_y     = wr.wr_y;
  assign in_range = (32'(wr_x) < FB_W) && (32'(wr_y) < FB_H);
  assign accept   = wr.wr_valid & wr_ready_q;
  assign wr_addr  = AW'(32'(wr_y) * FB_W + 32'(wr_x));

  assign wr.wr_ready = wr_ready_q;
  assign wr.wr_err   = wr_err_q;

  // Clear engine owns the memory write port while clearing.
  logic          mem_we, mem_wdata;
  logic [AW-1:0] mem_waddr;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_addr_q;
    mem_wdata = 1'b0;
    if (state_q == StClear) begin
      mem_we = 1'b1;
    end else if (accept && in_range) begin
      mem_we    = 1'b1;
      mem_waddr = wr_addr;
      mem_wdata = wr.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StClear;
      clr_addr_q <= '0;
      wr_ready_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      wr_err_q <= accept & ~in_range;
      unique case (state_q)
        StClear: begin
          if (wr.clr) begin
            clr_addr_q <= '0;
          end else if (clr_addr_q == AW'(FB_SIZE - 1)) begin
            state_q    <= StIdle;
            wr_ready_q <= 1'b1;
          end else begin
            clr_addr_q <= clr_addr_q + AW'(1);
          end
        end
        StIdle: begin
          // A write accepted in this cycle lands first, then the clear wipes it.
          if (wr.clr) begin
            state_q    <= StClear;
            clr_addr_q <= '0;
            wr_ready_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- memory
  // Read-before-write: a read in flight on the write edge returns the old bit.
  logic mem [FB_SIZE];
  logic pix_q;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    pix_q <= mem[rd_addr];
  end

  // Stage 1: strobes travelling alongside the memory read.
  logic act1_q, hs1_q, vs1_q, vb1_q, fs1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act1_q <= 1'b0;
      hs1_q  <= ~HS_POL;
      vs1_q  <= ~VS_POL;
      vb1_q  <= 1'b0;
      fs1_q  <= 1'b0;
    end else begin
      act1_q <= act0;
      hs1_q  <= hs0;
      vs1_q  <= vs0;
      vb1_q  <= vb0;
      fs1_q  <= fs0;
    end
  end

  // Stage 2: registered outputs.
  logic [7:0] color;

  assign color = act1_q ? (pix_q ? FG_COLOR : BG_COLOR) : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {R, G, B}   <= 8'h00;
      HS          <= ~HS_POL;
      VS          <= ~VS_POL;
      vblank      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      {R, G, B}   <= color;
      HS          <= hs1_q;
      VS          <= vs1_q;
      vblank      <= vb1_q;
      frame_start <= fs1_q;
    end
  end

endmodule

// File: tb/tb_vga_fb_scaler.sv
// Self-checking bench for vga_fb_scaler on a reduced 20x12 (10x6 framebuffer) timing.
module tb_vga_fb_scaler;

  localparam int HA = 20, HF = 2, HSY = 3, HB = 3, HT = HA + HF + HSY + HB;
  localparam int VA = 12, VF = 1, VSY = 2, VB = 1, VT = VA + VF + VSY + VB;
  localparam int FW = HA / 2, FH = VA / 2, FBN = FW * FH;
  localparam logic [7:0] FG = 8'hFF, BG = 8'h25;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hs, vs, vblank, frame_start;
  logic [2:0] r, g;
  logic [1:0] b;

  vga_fb_scaler_if #(.XW(4), .YW(3)) wr_if ();

  vga_fb_scaler #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .SCALE_SHIFT(1),
    .FG_COLOR(FG), .BG_COLOR(BG)
  ) u_dut (
    .clk(clk), .rst(rst), .wr(wr_if),
    .HS(hs), .VS(vs), .R(r), .G(g), .B(b),
    .vblank(vblank), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  // ------------------------------------------------------------ scoreboard
  typedef struct packed {
    logic [31:0] due;
    logic [7:0]  rgb;
    logic        hs, vs, vb, fs, chk;
  } exp_t;

  exp_t q[$];
  logic fb [FBN];
  bit   known [FBN];
  int   mh, mv, m_caddr, edge_cnt;
  bit   m_clr;
  logic m_ready, m_err;

  function automatic bit in_rng(input logic [3:0] x, input logic [2:0] y);
    return (int'(x) < FW) && (int'(y) < FH);
  endfunction

  function automatic exp_t expect_px(input int h, input int v, input int due);
    exp_t e;
    int   a;
    a     = (v / 2) * FW + h / 2;
    e.due = due;
    e.hs  = !(h >= HA + HF && h < HA + HF + HSY);
    e.vs  = !(v >= VA + VF && v < VA + VF + VSY);
    e.vb  = v >= VA;
    e.fs  = (h == 0) && (v == 0);
    e.rgb = 8'h00;
    e.chk = 1'b1;
    if (h < HA && v < VA) begin
      if (known[a]) e.rgb = fb[a] ? FG : BG;
      else e.chk = 1'b0;
    end
    return e;
  endfunction

  // Each edge: queue the pixel now being read (due after the following edge),
  // then apply that edge's writes to the shadow framebuffer.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mh <= 0; mv <= 0; m_clr <= 1'b1; m_caddr <= 0;
      m_ready <= 1'b0; m_err <= 1'b0; edge_cnt <= 0;
      q.delete();
      for (int i = 0; i < FBN; i++) known[i] <= 1'b0;
    end else begin
      edge_cnt <= edge_cnt + 1;
      q.push_back(expect_px(mh, mv, edge_cnt + 2));
      if (mh == HT - 1) begin
        mh <= 0;
        mv <= (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh <= mh + 1;
      end
      m_err <= wr_if.wr_valid && m_ready && !in_rng(wr_if.wr_x, wr_if.wr_y);
      if (m_clr) begin
        fb[m_caddr]    <= 1'b0;
        known[m_caddr] <= 1'b1;
        if (wr_if.clr) m_caddr <= 0;
        else if (m_caddr == FBN - 1) begin
          m_clr   <= 1'b0;
          m_ready <= 1'b1;
        end else m_caddr <= m_caddr + 1;
      end else begin
        if (wr_if.wr_valid && in_rng(wr_if.wr_x, wr_if.wr_y)) begin
          fb[int'(wr_if.wr_y) * FW + int'(wr_if.wr_x)]    <= wr_if.wr_data;
          known[int'(wr_if.wr_y) * FW + int'(wr_if.wr_x)] <= 1'b1;
        end
        if (wr_if.clr) begin
          m_clr   <= 1'b1;
          m_caddr <= 0;
          m_ready <= 1'b0;
        end
      end
    end
  end

  function automatic void chk_px(input exp_t e);
    if (e.due == 32'(edge_cnt)) begin
      if (e.chk) chk("pixel", {r, g, b, hs, vs, vblank, frame_start},
                     {e.rgb, e.hs, e.vs, e.vb, e.fs});
      else chk("timing", {hs, vs, vblank, frame_start}, {e.hs, e.vs, e.vb, e.fs});
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      while (q.size() > 0 && q[0].due <= 32'(edge_cnt)) chk_px(q.pop_front());
      chk("wr_ready", wr_if.wr_ready, m_ready);
      chk("wr_err", wr_if.wr_err, m_err);
    end
  end

  // ------------------------------------------------------------- directed
  task automatic check_reset(input string tag);
    chk({tag, "_rgb"}, {r, g, b}, 8'h00);
    chk({tag, "_sync"}, {hs, vs, vblank, frame_start}, 4'b1100);
    chk({tag, "_wr"}, {wr_if.wr_ready, wr_if.wr_err}, 2'b00);
  endtask

  task automatic count_ready_low(input string tag);
    int n = 0;
    while (!wr_if.wr_ready && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk(tag, n, FBN);
  endtask

  task automatic do_write(input int x, input int y, input logic d, input logic c);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_x     = 4'(x);
    wr_if.wr_y     = 3'(y);
    wr_if.wr_data  = d;
    wr_if.clr      = c;
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
    wr_if.clr      = 1'b0;
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 2 * HT * VT);
    chk("frame_start_seen", frame_start, 1'b1);
  endtask

  task automatic chk_pixel(input string tag, input int h, input int v, input logic [7:0] exp);
    wait_fs();
    repeat (v * HT + h) @(negedge clk);
    chk(tag, {r, g, b}, exp);
  endtask

  task automatic sync_check();
    int   hs_low = 0, vs_low = 0, vb_cnt = 0, fs_cnt = 0, hs_first = -1, vs_first = -1;
    logic phs = 1'b1, pvs = 1'b1;
    wait_fs();
    for (int i = 0; i < HT * VT; i++) begin
      if (!hs) hs_low++;
      if (!vs) vs_low++;
      if (vblank) vb_cnt++;
      if (frame_start) fs_cnt++;
      if (phs && !hs && hs_first < 0) hs_first = i;
      if (pvs && !vs && vs_first < 0) vs_first = i;
      phs = hs;
      pvs = vs;
      @(negedge clk);
    end
    chk("hs_first_fall", hs_first, HA + HF);
    chk("hs_low_per_frame", hs_low, HSY * VT);
    chk("vs_first_fall", vs_first, (VA + VF) * HT);
    chk("vs_low_per_frame", vs_low, VSY * HT);
    chk("vblank_per_frame", vb_cnt, (VT - VA) * HT);
    chk("fs_once_per_frame", fs_cnt, 1);
    chk("fs_period", frame_start, 1'b1);
  endtask

  initial begin
    wr_if.wr_valid = 1'b0;
    wr_if.wr_x     = '0;
    wr_if.wr_y     = '0;
    wr_if.wr_data  = 1'b0;
    wr_if.clr      = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    count_ready_low("init_clear_len");
    repeat (HT * VT) @(negedge clk);

    do_write(5, 3, 1'b1, 1'b0);
    chk_pixel("px_10_6_set", 10, 6, FG);
    chk_pixel("px_11_7_set", 11, 7, FG);
    chk_pixel("px_12_6_bg", 12, 6, BG);
    chk_pixel("px_10_5_bg", 10, 5, BG);
    do_write(5, 3, 1'b0, 1'b0);
    chk_pixel("px_10_6_back", 10, 6, BG);

    do_write(12, 0, 1'b1, 1'b0);
    chk("oor_x_err", wr_if.wr_err, 1'b1);
    @(negedge clk);
    chk("oor_x_err_end", wr_if.wr_err, 1'b0);
    do_write(3, 7, 1'b1, 1'b0);
    chk("oor_y_err", wr_if.wr_err, 1'b1);

    sync_check();

    do_write(0, 0, 1'b1, 1'b1);
    chk("clr_wr_no_err", wr_if.wr_err, 1'b0);
    count_ready_low("clr_clear_len");
    chk_pixel("px_0_0_cleared", 0, 0, BG);

    do_write(0, 0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    wr_if.clr = 1'b1;
    @(negedge clk);
    wr_if.clr = 1'b0;
    count_ready_low("clr_restart_len");

    do_write(0, 0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset("async_reset");
    @(negedge clk);
    rst = 1'b0;
    count_ready_low("post_reset_clear_len");
    repeat (HT * VT) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
